// File: rtl/sprite_scanline_renderer.sv
// sprite_scanline_renderer
// Renders one row of a single 1-bpp sprite per scanline. On line_start the
// sprite attributes are latched and the beam row is tested against the sprite's
// vertical extent. A hit fetches the bitmap row from an external synchronous
// ROM, waits for the beam to reach sprite_x, then shifts the row out as a
// registered pixel stream, magnified by 2^SCALE_LOG2 in both axes.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   line_start          : one-cycle pulse at the start of each scanline
//   hpos, vpos          : current beam position
//   sprite_x, sprite_y  : sprite top-left corner
//   hflip, vflip        : horizontal / vertical mirror
//   enable              : sprite enable
//   rom_addr            : bitmap row address (registered)
//   rom_data            : bitmap row, valid one cycle after rom_addr changes
//   gfx                 : registered pixel-on output
//   active              : high while the drawing window is open
module sprite_scanline_renderer #(
  parameter int SPR_W      = 8,
  parameter int SPR_H      = 16,
  parameter int SCALE_LOG2 = 0,
  parameter int COORD_W    = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     line_start,
  input  logic [COORD_W-1:0]       hpos,
  input  logic [COORD_W-1:0]       vpos,
  input  logic [COORD_W-1:0]       sprite_x,
  input  logic [COORD_W-1:0]       sprite_y,
  input  logic                     hflip,
  input  logic                     vflip,
  input  logic                     enable,
  output logic [$clog2(SPR_H)-1:0] rom_addr,
  input  logic [SPR_W-1:0]         rom_data,
  output logic                     gfx,
  output logic                     active
);
  localparam int AW = $clog2(SPR_H);
  localparam int IW = $clog2(SPR_W);
  // Draw counter spans 0..SPR_W<<SCALE_LOG2 inclusive; its upper IW bits are
  // the pixel index and the low SCALE_LOG2 bits the sub-pixel count.
  localparam int CW = IW + SCALE_LOG2 + 1;
  localparam logic [CW-1:0]      DRAW_LEN = CW'(SPR_W << SCALE_LOG2);
  localparam logic [COORD_W:0]   V_LIM    = (COORD_W+1)'(SPR_H << SCALE_LOG2);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WAIT_X, DRAW} state_t;

  state_t             state;
  logic [COORD_W-1:0] sx_q;
  logic               hflip_q;
  logic [SPR_W-1:0]   row_buf;
  logic [CW-1:0]      cnt;

  // Extra MSB makes a beam above the sprite come out as a huge unsigned
  // value, so a single compare rejects it: no vertical wrap-around.
  logic [COORD_W:0] dy;
  logic [AW-1:0]    dy_row;
  logic             v_hit;
  logic [IW-1:0]    pidx, pidx_r;
  logic             pix;

  always_comb begin
    dy     = {1'b0, vpos} - {1'b0, sprite_y};
    dy_row = dy[AW+SCALE_LOG2-1 -: AW];
    v_hit  = enable && (dy < V_LIM);
    // Entering DRAW always shows pixel 0; inside DRAW cnt already points at
    // the pixel for the next cycle.
    pidx   = (state == DRAW) ? cnt[IW+SCALE_LOG2-1 -: IW] : '0;
    pidx_r = ~pidx;  // SPR_W-1-idx, SPR_W being a power of two
    pix    = hflip_q ? row_buf[pidx] : row_buf[pidx_r];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sx_q     <= '0;
      hflip_q  <= 1'b0;
      row_buf  <= '0;
      cnt      <= '0;
      rom_addr <= '0;
      gfx      <= 1'b0;
      active   <= 1'b0;
    end else if (line_start) begin
      // Only attributes needed after this edge are kept; the vertical test
      // and vflip are fully resolved here.
      sx_q    <= sprite_x;
      hflip_q <= hflip;
      cnt     <= '0;
      gfx     <= 1'b0;
      active  <= 1'b0;
      if (v_hit) begin
        // Address goes out during FETCH so the synchronous ROM answers
        // in time for CAPTURE.
        rom_addr <= vflip ? ~dy_row : dy_row;
        state    <= FETCH;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        FETCH:   state <= CAPTURE;
        CAPTURE: begin
          row_buf <= rom_data;
          state   <= WAIT_X;
        end
        WAIT_X: begin
          if (hpos == sx_q) begin
            state  <= DRAW;
            gfx    <= pix;
            active <= 1'b1;
            cnt    <= CW'(1);
          end
        end
        DRAW: begin
          if (cnt == DRAW_LEN) begin
            state  <= IDLE;
            gfx    <= 1'b0;
            active <= 1'b0;
            cnt    <= '0;
          end else begin
            gfx <= pix;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Bench for sprite_scanline_renderer: two instances (scale 1x and 2x) share
// the stimulus. A line-level model predicts gfx/active/rom_addr each cycle;
// directed lines add literal expectations for the documented cases.
module tb_sprite_scanline_renderer;
  logic       clk = 1'b0;
  logic       reset, line_start, hflip, vflip, enable;
  logic [8:0] hpos, vpos, sprite_x, sprite_y;
  logic [3:0] rom_addr0, rom_addr1;
  logic [7:0] rom_data0, rom_data1;
  logic       gfx0, gfx1, active0, active1;
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  // Synchronous ROMs: data for an address appears after the next edge.
  always @(posedge clk) begin
    rom_data0 <= mem[rom_addr0];
    rom_data1 <= mem[rom_addr1];
  end

  sprite_scanline_renderer #(.SPR_W(8), .SPR_H(16), .SCALE_LOG2(0), .COORD_W(9)) u0 (
    .clk(clk), .reset(reset), .line_start(line_start), .hpos(hpos), .vpos(vpos),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .hflip(hflip), .vflip(vflip),
    .enable(enable), .rom_addr(rom_addr0), .rom_data(rom_data0), .gfx(gfx0),
    .active(active0));

  sprite_scanline_renderer #(.SPR_W(8), .SPR_H(16), .SCALE_LOG2(1), .COORD_W(9)) u1 (
    .clk(clk), .reset(reset), .line_start(line_start), .hpos(hpos), .vpos(vpos),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .hflip(hflip), .vflip(vflip),
    .enable(enable), .rom_addr(rom_addr1), .rom_data(rom_data1), .gfx(gfx1),
    .active(active1));

  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string nm, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, want);
  endfunction

  // ---------------- line-level model ----------------
  int         cyc = 0;
  bit         armed = 0;
  bit         m_valid [2];
  int         m_L [2], m_hit [2], m_addr [2];
  logic [8:0] m_sx [2];
  bit         m_hf [2];
  logic [7:0] m_bits [2];
  // per-line records of DUT outputs, indexed by the hpos sampled at the edge
  int rec_g [2][512];
  int rec_a [2][512];
  int cnt_g [2], cnt_a [2], last_addr [2];

  always begin : monitor
    logic       s_r, s_ls, s_hf, s_vf, s_en;
    logic [8:0] s_h, s_v, s_sx, s_sy;
    int dy, row, n, p, eg, ea, g, a, ad;
    @(posedge clk);
    s_r = reset; s_ls = line_start; s_h = hpos; s_v = vpos;
    s_sx = sprite_x; s_sy = sprite_y; s_hf = hflip; s_vf = vflip; s_en = enable;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (s_r) begin
        armed = 1; m_valid[i] = 0; m_addr[i] = 0;
      end else if (s_ls) begin
        dy = int'(s_v) - int'(s_sy);
        m_valid[i] = s_en && dy >= 0 && dy < (16 << i);
        if (m_valid[i]) begin
          row = dy >> i;
          m_addr[i] = s_vf ? 15 - row : row;
          m_bits[i] = mem[m_addr[i]];
          m_L[i] = cyc; m_sx[i] = s_sx; m_hf[i] = s_hf; m_hit[i] = -1;
        end
      end else if (m_valid[i] && m_hit[i] < 0 && cyc >= m_L[i] + 3 && s_h == m_sx[i]) begin
        m_hit[i] = cyc;
      end
    end
    #1;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        n = 8 << i; eg = 0; ea = 0;
        if (m_valid[i] && m_hit[i] >= 0 && cyc - m_hit[i] < n) begin
          ea = 1;
          p = (cyc - m_hit[i]) >> i;
          eg = m_hf[i] ? int'(m_bits[i][p]) : int'(m_bits[i][7-p]);
        end
        g  = (i == 0) ? int'(gfx0) : int'(gfx1);
        a  = (i == 0) ? int'(active0) : int'(active1);
        ad = (i == 0) ? int'(rom_addr0) : int'(rom_addr1);
        chk($sformatf("u%0d_gfx@%0d", i, cyc), g, eg);
        chk($sformatf("u%0d_active@%0d", i, cyc), a, ea);
        chk($sformatf("u%0d_rom_addr@%0d", i, cyc), ad, m_addr[i]);
        rec_g[i][s_h] = g; rec_a[i][s_h] = a;
        cnt_g[i] += g; cnt_a[i] += a; last_addr[i] = ad;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_line(input int v, input int len, input int h0,
                          input int rst_at, input int chg_at);
    vpos = 9'(v);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (j == 0) begin
        for (int i = 0; i < 2; i++) begin
          cnt_g[i] = 0; cnt_a[i] = 0;
          for (int k = 0; k < 512; k++) begin rec_g[i][k] = 0; rec_a[i][k] = 0; end
        end
      end
      line_start = (j == 0);
      hpos  = 9'(h0 + j);
      reset = (j == rst_at);
      if (j == chg_at) begin
        // mid-line attribute churn must not affect the current line
        sprite_x = 9'($urandom); sprite_y = 9'($urandom);
        hflip = 1'($urandom); vflip = 1'($urandom); enable = 1'($urandom);
      end
    end
    @(negedge clk);
    line_start = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int tot;
    reset = 1; line_start = 0; hpos = 0; vpos = 0;
    sprite_x = 128; sprite_y = 128; hflip = 0; vflip = 0; enable = 1;
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    chk("reset_gfx", gfx0, 0); chk("reset_active", active0, 0);
    chk("reset_rom_addr", rom_addr0, 0); chk("reset_active_x2", active1, 0);
    @(negedge clk) reset = 0;

    // basic row 10000001 at vpos 128
    mem[0] = 8'b10000001;
    run_line(128, 160, 0, -1, -1);
    chk("basic_rom_addr", last_addr[0], 0);
    chk("basic_g128", rec_g[0][128], 1);
    chk("basic_g135", rec_g[0][135], 1);
    for (int h = 129; h <= 134; h++) chk($sformatf("basic_g%0d", h), rec_g[0][h], 0);
    chk("basic_g127", rec_g[0][127], 0);
    chk("basic_g136", rec_g[0][136], 0);
    chk("basic_active_len", cnt_a[0], 8);

    // horizontal mirror
    mem[0] = 8'b11000000; hflip = 1;
    run_line(128, 160, 0, -1, -1);
    chk("hflip_g134", rec_g[0][134], 1);
    chk("hflip_g135", rec_g[0][135], 1);
    chk("hflip_cnt", cnt_g[0], 2);

    // vertical mirror
    hflip = 0; vflip = 1;
    run_line(128, 160, 0, -1, -1);
    chk("vflip_rom_addr", last_addr[0], 15);
    chk("vflip_rom_addr_x2", last_addr[1], 15);
    vflip = 0;

    // 2x magnification
    mem[0] = 8'b10000000;
    run_line(128, 160, 0, -1, -1);
    chk("x2_gfx_cycles", cnt_g[1], 2);
    chk("x2_active_cycles", cnt_a[1], 16);
    chk("x2_g129", rec_g[1][129], 1);
    chk("x1_gfx_cycles", cnt_g[0], 1);
    run_line(159, 160, 0, -1, -1);
    chk("x2_v159_rom_addr", last_addr[1], 15);
    chk("x2_v159_active", cnt_a[1], 16);
    chk("x1_v159_idle", cnt_a[0], 0);
    run_line(160, 160, 0, -1, -1);
    chk("x2_v160_idle", cnt_a[1], 0);

    // no vertical wrap-around
    sprite_y = 500; mem[0] = 8'hFF; tot = 0;
    for (int v = 0; v < 12; v++) begin
      run_line(v, 160, 0, -1, -1);
      tot += cnt_a[0] + cnt_a[1];
    end
    chk("nowrap_active", tot, 0);

    // sprite_x reached before WAIT_X: skipped; one pixel later it draws
    sprite_y = 128; sprite_x = 2;
    run_line(128, 160, 0, -1, -1);
    chk("early_x_u0", cnt_a[0], 0);
    chk("early_x_u1", cnt_a[1], 0);
    sprite_x = 3;
    run_line(128, 160, 0, -1, -1);
    chk("x3_u0", cnt_a[0], 8);
    chk("x3_u1", cnt_a[1], 16);
    chk("x3_g3", rec_g[0][3], 1);

    // reset mid-DRAW
    sprite_x = 128;
    run_line(128, 160, 0, 131, -1);
    chk("rst_mid_was_active", rec_a[0][130], 1);
    chk("rst_mid_gfx", rec_g[0][131], 0);
    chk("rst_mid_active", rec_a[0][131], 0);
    chk("rst_mid_active_x2", rec_a[1][131], 0);

    // enable dropped mid-line
    run_line(128, 160, 0, -1, -1);
    @(negedge clk);
    enable = 1;
    begin
      // drop enable at hpos 50 of the next line
      fork
        run_line(128, 160, 0, -1, -1);
        begin repeat (50) @(negedge clk); enable = 0; end
      join
    end
    chk("en_drop_cur_line", cnt_a[0], 8);
    run_line(128, 160, 0, -1, -1);
    chk("en_drop_next_line", cnt_a[0], 0);
    enable = 1;

    // randomized lines
    for (int t = 0; t < 70; t++) begin
      int len, yoff, rst_at, chg_at;
      for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
      sprite_y = 9'($urandom);
      yoff     = int'($urandom_range(0, 40)) - 4;
      sprite_x = 9'($urandom_range(0, 220));
      hflip    = 1'($urandom); vflip = 1'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      len      = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6))
                                             : int'($urandom_range(20, 280));
      rst_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
      chg_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : -1;
      run_line((int'(sprite_y) + yoff) & 511, len, int'($urandom_range(0, 60)),
               rst_at, chg_at);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sprite_scanline_renderer.md
SPRITE_SCANLINE_RENDERER -- requirements
Module: sprite_scanline_renderer

Interface
REQ-001 SHALL have parameter SPR_W, default 8: sprite width in pixels; legal values 8 or 16.
REQ-002 SHALL have parameter SPR_H, default 16: sprite height in rows; power of two, 2..64.
REQ-003 SHALL have parameter SCALE_LOG2, default 0: pixel magnification 2^SCALE_LOG2 in both axes; legal values 0..2.
REQ-004 SHALL have parameter COORD_W, default 9: width of position and coordinate buses.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port line_start, input, 1 bit: one-cycle pulse at the start of each scanline.
REQ-008 SHALL have ports hpos and vpos, input, COORD_W bits each: current beam position.
REQ-009 SHALL have ports sprite_x and sprite_y, input, COORD_W bits each: sprite top-left corner.
REQ-010 SHALL have ports hflip, vflip and enable, input, 1 bit each: mirror controls and sprite enable.
REQ-011 SHALL have port rom_addr, output, log2(SPR_H) bits: bitmap row address, registered.
REQ-012 SHALL have port rom_data, input, SPR_W bits: bitmap row, valid exactly 1 cycle after rom_addr changes.
REQ-013 SHALL have port gfx, output, 1 bit: registered pixel-on output.
REQ-014 SHALL have port active, output, 1 bit: high while the drawing window is open.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, CAPTURE, WAIT_X and DRAW.
REQ-016 SHALL, on line_start in any state, latch sprite_x, sprite_y, hflip, vflip and enable; mid-line input changes take effect at the next line_start only.
REQ-017 SHALL, on line_start, compute dy = vpos - latched sprite_y in COORD_W+1 bits, go to FETCH if enable and 0 <= dy < SPR_H<<SCALE_LOG2, else go to IDLE; no vertical wrap-around.
REQ-018 SHALL, in FETCH, drive rom_addr = row when vflip=0 or SPR_H-1-row when vflip=1, where row = dy>>SCALE_LOG2, then go to CAPTURE.
REQ-019 SHALL, in CAPTURE, register rom_data into a row buffer, then go to WAIT_X.
REQ-020 SHALL, in WAIT_X, go to DRAW on the cycle hpos equals the latched sprite_x, with pixel index 0 and sub-pixel counter 0.
REQ-021 SHALL stay in WAIT_X until the next line_start if hpos == sprite_x occurs before WAIT_X is reached (line_start less than 3 cycles ahead); the sprite is not drawn on that line.
REQ-022 SHALL, in DRAW, set gfx = row_buf[SPR_W-1-idx] for hflip=0 (MSB leftmost) or row_buf[idx] for hflip=1.
REQ-023 SHALL, in DRAW, hold idx for 2^SCALE_LOG2 cycles per pixel, and assert active.
REQ-024 SHALL leave DRAW for IDLE after exactly SPR_W<<SCALE_LOG2 cycles, or earlier on line_start (that line_start is handled per REQ-016).
REQ-025 SHALL register gfx so that it reflects the pixel for the hpos sampled on the previous cycle: first lit pixel at cycle T+1 where hpos == sprite_x at T; gfx = 0 outside DRAW.
REQ-026 SHALL perform no horizontal wrap-around; a sprite extending past line end is truncated by the line_start abort.
REQ-027 SHALL ignore line_start coinciding with reset.

Reset
REQ-028 SHALL, on reset, force state IDLE, gfx=0, active=0, rom_addr=0 and clear the row buffer and counters by the next clock edge, including mid-DRAW.
REQ-029 SHALL keep gfx=0 after reset release until a full FETCH/CAPTURE/WAIT_X sequence completes.

Verification
REQ-030 SHALL cover: defaults, sprite_x=sprite_y=128, row 0 = 8'b10000001, line_start at hpos=0 with vpos=128 -> rom_addr=0, gfx=1 at hpos 128 and 135 (one cycle later), 0 at 129..134.
REQ-031 SHALL cover: same case with hflip=1 and row 8'b11000000 -> gfx high for pixels 6,7 only; vflip=1 at vpos=128 -> rom_addr=15.
REQ-032 SHALL cover: SCALE_LOG2=1 with row 8'b10000000 -> gfx high 2 cycles, active high 16 cycles; vpos=159 -> rom_addr=15; vpos=160 -> stays IDLE.
REQ-033 SHALL cover: sprite_y=500, COORD_W=9 -> never drawn at vpos 0..11 (no wrap); sprite_x=2 with line_start at hpos=0 -> not drawn on that line.
REQ-034 SHALL cover: reset asserted mid-DRAW -> gfx=0, active=0 next cycle; enable dropped mid-line -> current line completes, next line blank.
